// File: rtl/adv_pkg.sv
// Shared definitions for the advance-button controller: channel FSM states,
// counter width and default timing parameters.
package adv_pkg;

  localparam int CNT_W             = 8;
  localparam int DEF_DEBOUNCE_CYC  = 4;
  localparam int DEF_REPEAT_DELAY  = 16;
  localparam int DEF_REPEAT_PERIOD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_HELD,
    ST_REPEAT,
    ST_RELEASE
  } chan_state_t;

endpackage

// File: rtl/adv_chan.sv
// One button channel: 2-flop synchronizer, debounce/hold/repeat FSM and a
// registered single-cycle advance strobe. Auto-repeat exists only when
// ADV_AUTO_REPEAT_EN is defined.
module adv_chan
  import adv_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic btn,
  output logic adv
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC);
`ifdef ADV_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > 255 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > 255) begin : g_param_check
    $error("adv_chan: timing parameters must lie in 1..255");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic              btn_p0;
  logic              btn_p1;
  chan_state_t       state;
  logic [CNT_W-1:0]  cnt;

  // Stage p0/p1: metastability synchronizer on the raw button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= btn;
      btn_p1 <= btn_p0;
    end
  end

  // Stage p2: channel FSM; the strobe register is pulsed for one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      adv   <= 1'b0;
    end else begin
      adv <= 1'b0;
      if (!en) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (btn_p1) begin
              state <= ST_PRESS;
              cnt   <= CNT_W'(1);
            end else begin
              cnt <= '0;
            end
          end
          ST_PRESS: begin
            if (!btn_p1) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              adv   <= 1'b1;
              state <= ST_HELD;
              cnt   <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          ST_HELD: begin
            if (!btn_p1) begin
              state <= ST_RELEASE;
              cnt   <= CNT_W'(1);
`ifdef ADV_AUTO_REPEAT_EN
            end else if (cnt == DLY_LAST) begin
              adv   <= 1'b1;
              state <= ST_REPEAT;
              cnt   <= '0;
`endif
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          ST_REPEAT: begin
            if (!btn_p1) begin
              state <= ST_RELEASE;
              cnt   <= CNT_W'(1);
`ifdef ADV_AUTO_REPEAT_EN
            end else if (cnt == PER_LAST) begin
              adv <= 1'b1;
              cnt <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
`else
            end else begin
              state <= ST_HELD;
              cnt   <= '0;
            end
`endif
          end
          ST_RELEASE: begin
            // A high sample here is contact bounce, so it returns to HELD silently
            if (btn_p1) begin
              state <= ST_HELD;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/adv_button_ctrl.sv
// Five-button advance controller: mode-based enable gating around five
// adv_chan instances. Optional auto-repeat via ADV_AUTO_REPEAT_EN.
module adv_button_ctrl
  import adv_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic timeset,
  input  logic alarmset,
  input  logic minbtn,
  input  logic hrsbtn,
  input  logic daybtn,
  input  logic datebtn,
  input  logic monthbtn,
  output logic minadv,
  output logic hrsadv,
  output logic dayadv,
  output logic dateadv,
  output logic monthadv
);

  logic       time_en;
  logic       date_en;
  logic [4:0] btns;
  logic [4:0] ens;
  logic [4:0] advs;

  // Time fields are settable in both modes; calendar fields only in time-set mode
  assign time_en = timeset | alarmset;
  assign date_en = timeset & ~alarmset;

  assign btns = {monthbtn, datebtn, daybtn, hrsbtn, minbtn};
  assign ens  = {date_en, date_en, date_en, time_en, time_en};

  for (genvar i = 0; i < 5; i++) begin : g_chan
    adv_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .en   (ens[i]),
      .btn  (btns[i]),
      .adv  (advs[i])
    );
  end

  assign {monthadv, dateadv, dayadv, hrsadv, minadv} = advs;

endmodule

// File: tb/tb_adv_button_ctrl.sv
// Directed bench for adv_button_ctrl: expected strobe cycles are queued as
// stimulus is applied and compared against all five outputs every cycle.
module tb_adv_button_ctrl;

  localparam int CH_MIN = 0, CH_HRS = 1, CH_DAY = 2, CH_DATE = 3, CH_MONTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic timeset = 1'b0, alarmset = 1'b0;
  logic minbtn = 1'b0, hrsbtn = 1'b0, daybtn = 1'b0, datebtn = 1'b0, monthbtn = 1'b0;
  logic minadv, hrsadv, dayadv, dateadv, monthadv;

  typedef struct {
    int cyc;
    int ch;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  adv_button_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .timeset (timeset),
    .alarmset(alarmset),
    .minbtn  (minbtn),
    .hrsbtn  (hrsbtn),
    .daybtn  (daybtn),
    .datebtn (datebtn),
    .monthbtn(monthbtn),
    .minadv  (minadv),
    .hrsadv  (hrsadv),
    .dayadv  (dayadv),
    .dateadv (dateadv),
    .monthadv(monthadv)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: a strobe expected at edge N is seen at the negedge after edge N
  always @(negedge clk) begin
    logic [4:0] exp_v;
    logic [4:0] obs_v;
    exp_v = '0;
    obs_v = {monthadv, dateadv, dayadv, hrsadv, minadv};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        exp_v[sb[i].ch] = 1'b1;
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $error("FAIL expired_wait cyc=%0d ch=%0d expected at %0d", cyc, sb[i].ch, sb[i].cyc);
        sb.delete(i);
      end
    end
    checks++;
    assert (obs_v === exp_v)
    else begin
      errors++;
      $error("FAIL adv_strobes cyc=%0d observed=%b expected=%b", cyc, obs_v, exp_v);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int c, input int ch);
    sb.push_back('{cyc: c, ch: ch});
  endtask

  initial begin
    int k;

    // Reset held: all strobes must stay low
    step(3);
    checks++;
    if ({monthadv, dateadv, dayadv, hrsadv, minadv} !== 5'b00000) begin
      errors++;
      $error("FAIL reset_state strobes=%b", {monthadv, dateadv, dayadv, hrsadv, minadv});
    end
    reset = 1'b0;
    step(3);

    // Single press, held 10 cycles: one Minadv at edge 7
    timeset = 1'b1;
    k = cyc;
    minbtn = 1'b1;
    expect_at(k + 7, CH_MIN);
    step(10);
    minbtn = 1'b0;
    step(15);

    // Long hold on Hrsbtn for 40 cycles
    k = cyc;
    hrsbtn = 1'b1;
    expect_at(k + 7, CH_HRS);
`ifdef ADV_AUTO_REPEAT_EN
    expect_at(k + 23, CH_HRS);
    expect_at(k + 27, CH_HRS);
    expect_at(k + 31, CH_HRS);
    expect_at(k + 35, CH_HRS);
    expect_at(k + 39, CH_HRS);
`endif
    step(40);
    hrsbtn = 1'b0;
    step(15);

    // Bouncing Datebtn never debounces, then a clean 8-cycle hold strobes once
    for (int i = 0; i < 3; i++) begin
      datebtn = 1'b1;
      step(2);
      datebtn = 1'b0;
      step(2);
    end
    k = cyc;
    datebtn = 1'b1;
    expect_at(k + 7, CH_DATE);
    step(8);
    datebtn = 1'b0;
    step(15);

    // Alarm-set mode: Minadv allowed, Monthadv gated off
    timeset  = 1'b0;
    alarmset = 1'b1;
    k = cyc;
    monthbtn = 1'b1;
    minbtn   = 1'b1;
    expect_at(k + 7, CH_MIN);
    step(10);
    monthbtn = 1'b0;
    minbtn   = 1'b0;
    step(15);

    // All five pressed together: simultaneous strobes
    timeset  = 1'b1;
    alarmset = 1'b0;
    k = cyc;
    {monthbtn, datebtn, daybtn, hrsbtn, minbtn} = 5'b11111;
    for (int ch = 0; ch < 5; ch++) expect_at(k + 7, ch);
    step(10);
    {monthbtn, datebtn, daybtn, hrsbtn, minbtn} = 5'b00000;
    step(15);

    // One-cycle disable mid-debounce restarts the Daybtn press
    k = cyc;
    daybtn = 1'b1;
    step(4);
    alarmset = 1'b1;
    step(1);
    alarmset = 1'b0;
    expect_at(k + 10, CH_DAY);
    step(7);
    daybtn = 1'b0;
    step(15);

    // Reset pulse mid-press discards it; a full debounce follows release of reset
    k = cyc;
    daybtn = 1'b1;
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_at(k + 13, CH_DAY);
    step(10);
    daybtn = 1'b0;
    step(15);

    // Neither mode active: no channel may strobe
    timeset  = 1'b0;
    alarmset = 1'b0;
    minbtn   = 1'b1;
    daybtn   = 1'b1;
    step(10);
    minbtn   = 1'b0;
    daybtn   = 1'b0;
    step(10);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $error("FAIL pending_expectations count=%0d", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adv_button_ctrl.md
ADV_BUTTON_CTRL -- requirements
Module: adv_button_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4: consecutive stable synchronized cycles needed to accept a press or release; legal range 1..255.
REQ-002 Parameter REPEAT_DELAY, default 16: held cycles after the first advance before auto-repeat starts; legal range 1..255.
REQ-003 Parameter REPEAT_PERIOD, default 4: cycles between auto-repeat advances; legal range 1..255.
REQ-004 Clk  in  1  single system clock, rising-edge active.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 Timeset  in  1  time/date set mode, level.
REQ-007 Alarmset  in  1  alarm set mode, level.
REQ-008 Minbtn, Hrsbtn, Daybtn, Datebtn, Monthbtn  in  1 each  raw asynchronous push buttons, active-high.
REQ-009 Minadv, Hrsadv, Dayadv, Dateadv, Monthadv  out  1 each  single-cycle advance strobes to the clock core, registered.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each of the five channels SHALL run an independent FSM with states IDLE, PRESS, HELD, REPEAT, RELEASE, plus an 8-bit counter.
REQ-012 IDLE: counter = 0; synchronized button high -> PRESS, counter = 1.
REQ-013 PRESS: button high increments the counter; when counter = DEBOUNCE_CYC, emit one strobe, go HELD, counter = 0; button low -> IDLE, no strobe.
REQ-014 HELD: count held cycles; when counter reaches REPEAT_DELAY, emit strobe, go REPEAT, counter = 0; button low -> RELEASE.
REQ-015 REPEAT: emit one strobe every REPEAT_PERIOD cycles; button low -> RELEASE.
REQ-016 RELEASE: DEBOUNCE_CYC consecutive low cycles -> IDLE; button high before that -> HELD with counter = 0 and no strobe (a bounce is never a new press).
REQ-017 Latency: with the raw button high and stable from clock edge 0, the first strobe SHALL be high for exactly one cycle at edge DEBOUNCE_CYC+3.
REQ-018 Enable gating:
  - Minadv and Hrsadv are enabled when Timeset or Alarmset is high.
  - Dayadv, Dateadv and Monthadv are enabled only when Timeset is high and Alarmset is low.
REQ-019 A disabled channel SHALL be synchronously forced to IDLE with counter 0; its strobe is low that cycle.
REQ-020 Simultaneous presses on multiple channels SHALL produce simultaneous strobes; no arbitration.
REQ-021 Counters SHALL saturate and never wrap.

Reset
REQ-022 Reset high SHALL immediately clear all synchronizers, FSMs to IDLE, counters to 0, and all five strobes to 0.
REQ-023 Reset asserted mid-press SHALL discard the press; after release of Reset, a still-held button is treated as a new press (full debounce).

Configuration
REQ-024 Macro ADV_AUTO_REPEAT_EN defined: REPEAT state active as in REQ-014 and REQ-015.
REQ-025 Macro ADV_AUTO_REPEAT_EN undefined:
  - HELD never times out; exactly one strobe per debounced press.
  - REPEAT state and parameters REPEAT_DELAY/REPEAT_PERIOD are unused.

Structure
REQ-026 Shared package adv_pkg SHALL hold the channel FSM state enum, the counter width constant (8), and the default parameter values.
REQ-027 One sub-module adv_chan (synchronizer, FSM, counter, strobe register) SHALL be instantiated five times; the top holds only enable gating and instances.

Verification
REQ-028 Timeset = 1, Minbtn high held 10 cycles, defaults -> exactly one Minadv pulse at edge 7, nothing else.
REQ-029 Timeset = 1, Hrsbtn held 40 cycles, ADV_AUTO_REPEAT_EN defined -> Hrsadv pulses at edges 7, 23, 27, 31, 35, 39 (six strobes, plus any due before release debounce completes).
REQ-030 Bounce: Datebtn toggles high/low every 2 cycles for 12 cycles, Timeset = 1 -> no Dateadv; then held 8 cycles -> exactly one Dateadv.
REQ-031 Alarmset = 1, Timeset = 0, Monthbtn and Minbtn held 10 cycles -> Minadv fires once, Monthadv never fires.
REQ-032 Reset pulsed at cycle 5 while Daybtn is held (Timeset = 1) -> no Dayadv before edge DEBOUNCE_CYC+3 after Reset falls, then one Dayadv.
REQ-033 Same stimulus as REQ-029 with ADV_AUTO_REPEAT_EN undefined -> exactly one Hrsadv.
